// File: rtl/api_pllf.sv
// PLL-configuration FIFO between api_slave (writer) and api_ctrl (reader).
// Standard (non-FWFT) mode: dout updates on the edge that accepts a read.
module api_pllf #(
  parameter int WIDTH = 104,
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int CW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    data_count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] dout_q;

  logic clear;
  logic full_w;
  logic empty_w;
  logic wr_acc;
  logic rd_acc;

  // Flags come straight from the registered count, so they reflect pre-edge state.
  always_comb begin
    clear   = rst | flush;
    full_w  = (count_q == FULL_COUNT);
    empty_w = (count_q == '0);
    wr_acc  = wr_en & ~full_w;
    rd_acc  = rd_en & ~empty_w;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en & ~wr_acc;
    underflow_d = rd_en & ~rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; only the write is suppressed during reset/flush.
  always_ff @(posedge clk) begin
    if (wr_acc && !clear) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= mem[rd_ptr_q];
    end
  end

  assign full       = full_w;
  assign empty      = empty_w;
  assign data_count = count_q;
  assign dout       = dout_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_api_pllf.sv
// Self-checking bench for api_pllf: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_api_pllf;
  localparam int WIDTH = 104;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int CW    = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    data_count;
  logic             overflow;
  logic             underflow;

  api_pllf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .din        (din),
    .wr_en      (wr_en),
    .full       (full),
    .rd_en      (rd_en),
    .dout       (dout),
    .empty      (empty),
    .data_count (data_count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus the visible output registers.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf;
  logic             m_udf;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[WIDTH-1:0];
  endfunction

  // One clock: drive inputs, advance the model from pre-edge state, compare.
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d,
                      input logic fl, input logic rs);
    bit m_full, m_empty, wacc, racc;
    wr_en = w; rd_en = r; din = d; flush = fl; rst = rs;
    @(posedge clk);
    #1;
    if (rs || fl) begin
      model_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      m_full  = (model_q.size() == DEPTH);
      m_empty = (model_q.size() == 0);
      wacc = w && !m_full;
      racc = r && !m_empty;
      if (racc) m_dout = model_q.pop_front();
      if (wacc) model_q.push_back(d);
      m_ovf = w && !wacc;
      m_udf = r && !racc;
    end
    check("count",     WIDTH'(data_count), WIDTH'(model_q.size()));
    check("empty",     WIDTH'(empty),      WIDTH'(model_q.size() == 0));
    check("full",      WIDTH'(full),       WIDTH'(model_q.size() == DEPTH));
    check("dout",      dout,               m_dout);
    check("overflow",  WIDTH'(overflow),   WIDTH'(m_ovf));
    check("underflow", WIDTH'(underflow),  WIDTH'(m_udf));
    $display("cyc wr=%0d rd=%0d fl=%0d rst=%0d count=%0d dout=%h ovf=%0d udf=%0d",
             w, r, fl, rs, data_count, dout, overflow, underflow);
  endtask

  task automatic wr(input logic [WIDTH-1:0] d); step(1'b1, 1'b0, d, 1'b0, 1'b0); endtask
  task automatic rd();                         step(1'b0, 1'b1, '0, 1'b0, 1'b0); endtask
  task automatic idle();                       step(1'b0, 1'b0, '0, 1'b0, 1'b0); endtask

  initial begin
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;

    // T1: reset held with both requests high
    step(1'b1, 1'b1, rand_word(), 1'b0, 1'b1);
    step(1'b1, 1'b1, rand_word(), 1'b0, 1'b1);
    idle();

    // T2: fill with 0..63, one rejected write, drain in order
    for (int i = 0; i < DEPTH; i++) wr(WIDTH'(i));
    wr(WIDTH'(999));
    for (int i = 0; i < DEPTH; i++) rd();
    idle();

    // T3: pointer wrap
    for (int i = 0; i < 40; i++) wr(rand_word());
    for (int i = 0; i < 40; i++) rd();
    for (int i = 0; i < 50; i++) wr(rand_word());
    for (int i = 0; i < 50; i++) rd();

    // T4: simultaneous read/write at mid, full and empty
    for (int i = 0; i < 10; i++) wr(rand_word());
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, rand_word(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) rd();
    for (int i = 0; i < DEPTH; i++) wr(rand_word());
    step(1'b1, 1'b1, rand_word(), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) rd();
    step(1'b1, 1'b1, rand_word(), 1'b0, 1'b0);
    rd();

    // T5: flush while writing at count 30
    for (int i = 0; i < 30; i++) wr(rand_word());
    step(1'b1, 1'b0, rand_word(), 1'b1, 1'b0);
    idle();

    // T6: reads on empty
    for (int i = 0; i < 3; i++) rd();
    idle();

    // Random traffic with occasional flushes; bias shifts to exercise both ends
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 500) % 2 == 0) ? 70 : 30;
      step(($urandom_range(99) < wp), ($urandom_range(99) < (100 - wp)),
           rand_word(), ($urandom_range(399) == 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
